// File: rtl/ccr_unit.sv
// Condition-code register with branch resolve bypass and interrupt shadow stack.
// Optional: `define CCR_BRANCH_CLR_EN makes taken conditional branches clear the tested flag.
module ccr_unit #(
  parameter int SHADOW_DEPTH = 2,
  parameter int SP_W         = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [3:0]      alu_flags,
  input  logic [3:0]      flag_wr_mask,
  input  logic            flag_valid,
  input  logic [2:0]      branch_type,
  input  logic            branch_valid,
  input  logic            int_save,
  input  logic            int_restore,
  output logic [3:0]      ccr,
  output logic            carry_out,
  output logic            branch_taken,
  output logic            shadow_err,
  output logic [SP_W-1:0] shadow_depth
);

  localparam int NENT = 1 << SP_W;

  localparam logic [2:0] BR_JZ  = 3'd1;
  localparam logic [2:0] BR_JN  = 3'd2;
  localparam logic [2:0] BR_JC  = 3'd3;
  localparam logic [2:0] BR_JV  = 3'd4;
  localparam logic [2:0] BR_JMP = 3'd5;

  // Stack FSM state is the depth itself
  localparam logic [SP_W-1:0] ST_EMPTY = '0;
  localparam logic [SP_W-1:0] ST_FULL  = SP_W'(SHADOW_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);

  logic [3:0]      ccr_q, ccr_d;
  logic [SP_W-1:0] depth_q, depth_d;
  logic            err_q, err_d;
  logic [3:0]      stk_q [NENT];

  logic [3:0] wr_en;
  logic [3:0] eff;
  logic [3:0] top;
  logic       cond;
  logic       full, empty;
  logic       save_req, rest_req, both_req;
  logic       do_push, do_pop;

  assign wr_en = {4{flag_valid & ~flush}} & flag_wr_mask;
  assign eff   = (alu_flags & wr_en) | (ccr_q & ~wr_en);

  always_comb begin
    cond = 1'b0;
    unique case (branch_type)
      BR_JZ:   cond = eff[0];
      BR_JN:   cond = eff[1];
      BR_JC:   cond = eff[2];
      BR_JV:   cond = eff[3];
      BR_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken = cond & branch_valid
                      & ~stall & ~flush & ~reset;

  assign full  = (depth_q == ST_FULL);
  assign empty = (depth_q == ST_EMPTY);
  assign top   = stk_q[depth_q - SP_ONE];

  assign save_req = int_save & ~int_restore & ~flush & ~stall;
  assign rest_req = int_restore & ~int_save & ~flush & ~stall;
  assign both_req = int_save & int_restore & ~flush & ~stall;
  assign do_push  = save_req & ~full;
  assign do_pop   = rest_req & ~empty;

`ifdef CCR_BRANCH_CLR_EN
  logic [3:0] clr_mask;

  always_comb begin
    clr_mask = 4'b0000;
    if (branch_taken) begin
      unique case (branch_type)
        BR_JZ:   clr_mask = 4'b0001;
        BR_JN:   clr_mask = 4'b0010;
        BR_JC:   clr_mask = 4'b0100;
        BR_JV:   clr_mask = 4'b1000;
        default: clr_mask = 4'b0000;
      endcase
    end
  end
`endif

  always_comb begin
`ifdef CCR_BRANCH_CLR_EN
    ccr_d = eff & ~clr_mask;
`else
    ccr_d = eff;
`endif
    if (do_pop) ccr_d = top;
  end

  always_comb begin
    depth_d = depth_q;
    if (do_push) depth_d = depth_q + SP_ONE;
    if (do_pop)  depth_d = depth_q - SP_ONE;
  end

  assign err_d = err_q
               | (save_req & full)
               | (rest_req & empty)
               | both_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      ccr_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < NENT; k++) stk_q[k] <= '0;
    end else if (!stall) begin
      ccr_q   <= ccr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      if (do_push) stk_q[depth_q] <= eff;
    end
  end

  assign ccr          = ccr_q;
  assign carry_out    = ccr_q[2];
  assign shadow_err   = err_q;
  assign shadow_depth = depth_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed self-checking bench for ccr_unit.
// Expected values are hand-derived; clear-on-branch expectations follow CCR_BRANCH_CLR_EN.
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic       flush;
  logic [3:0] alu_flags;
  logic [3:0] flag_wr_mask;
  logic       flag_valid;
  logic [2:0] branch_type;
  logic       branch_valid;
  logic       int_save;
  logic       int_restore;
  logic [3:0] ccr;
  logic       carry_out;
  logic       branch_taken;
  logic       shadow_err;
  logic [1:0] shadow_depth;

  int tests = 0;
  int fails = 0;

  ccr_unit #(.SHADOW_DEPTH(2), .SP_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .alu_flags    (alu_flags),
    .flag_wr_mask (flag_wr_mask),
    .flag_valid   (flag_valid),
    .branch_type  (branch_type),
    .branch_valid (branch_valid),
    .int_save     (int_save),
    .int_restore  (int_restore),
    .ccr          (ccr),
    .carry_out    (carry_out),
    .branch_taken (branch_taken),
    .shadow_err   (shadow_err),
    .shadow_depth (shadow_depth)
  );

  always #5 clk = ~clk;

  task automatic idle;
    reset        = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    alu_flags    = 4'h0;
    flag_wr_mask = 4'h0;
    flag_valid   = 1'b0;
    branch_type  = 3'd0;
    branch_valid = 1'b0;
    int_save     = 1'b0;
    int_restore  = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] f);
    idle();
    flag_valid   = 1'b1;
    flag_wr_mask = 4'hF;
    alu_flags    = f;
    tick();
    idle();
  endtask

  task automatic test_reset;
    idle();
    reset        = 1'b1;
    branch_valid = 1'b1;
    branch_type  = 3'd5;
    tick();
    tick();
    tests++;
    if (branch_taken !== 1'b0) begin
      fails++;
      $display("FAIL rst_taken got %b exp 0", branch_taken);
    end
    tests++;
    if (ccr !== 4'h0 || carry_out !== 1'b0) begin
      fails++;
      $display("FAIL rst_ccr got %h/%b exp 0/0", ccr, carry_out);
    end
    tests++;
    if (shadow_depth !== 2'd0 || shadow_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_stack got %0d/%b exp 0/0",
               shadow_depth, shadow_err);
    end
    idle();
  endtask

  task automatic test_flag_write;
    idle();
    flag_valid   = 1'b1;
    flag_wr_mask = 4'hF;
    alu_flags    = 4'b0101;
    #1;
    tests++;
    if (branch_taken !== 1'b0) begin
      fails++;
      $display("FAIL wr_taken got %b exp 0", branch_taken);
    end
    tick();
    idle();
    tests++;
    if (ccr !== 4'b0101 || carry_out !== 1'b1) begin
      fails++;
      $display("FAIL wr_ccr got %h/%b exp 5/1", ccr, carry_out);
    end
  endtask

  task automatic test_bypass_jz;
    logic [3:0] exp_ccr;
`ifdef CCR_BRANCH_CLR_EN
    exp_ccr = 4'b0000;
`else
    exp_ccr = 4'b0001;
`endif
    wr(4'h0);
    flag_valid   = 1'b1;
    flag_wr_mask = 4'b0001;
    alu_flags    = 4'b0001;
    branch_valid = 1'b1;
    branch_type  = 3'd1;
    #1;
    tests++;
    if (branch_taken !== 1'b1) begin
      fails++;
      $display("FAIL jz_bypass got %b exp 1", branch_taken);
    end
    tick();
    idle();
    tests++;
    if (ccr !== exp_ccr) begin
      fails++;
      $display("FAIL jz_ccr got %h exp %h", ccr, exp_ccr);
    end
  endtask

  task automatic test_partial_mask;
    logic [2:0] bt [5];
    logic       ex [5];
    bt = '{3'd3, 3'd4, 3'd2, 3'd6, 3'd5};
    ex = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wr(4'b0100);
    flag_valid   = 1'b1;
    flag_wr_mask = 4'b0010;
    alu_flags    = 4'b1111;
    tick();
    idle();
    tests++;
    if (ccr !== 4'b0110) begin
      fails++;
      $display("FAIL mask_ccr got %h exp 6", ccr);
    end
    for (int i = 0; i < 5; i++) begin
      branch_valid = 1'b1;
      branch_type  = bt[i];
      #1;
      tests++;
      if (branch_taken !== ex[i]) begin
        fails++;
        $display("FAIL br_type%0d got %b exp %b",
                 bt[i], branch_taken, ex[i]);
      end
    end
    idle();
  endtask

  task automatic test_shadow;
    wr(4'b1010);
    int_save = 1'b1;
    tick();
    idle();
    tests++;
    if (shadow_depth !== 2'd1) begin
      fails++;
      $display("FAIL save_depth got %0d exp 1", shadow_depth);
    end
    wr(4'b0001);
    int_restore = 1'b1;
    tick();
    idle();
    tests++;
    if (ccr !== 4'b1010 || shadow_depth !== 2'd0
        || shadow_err !== 1'b0) begin
      fails++;
      $display("FAIL restore got %h/%0d/%b exp a/0/0",
               ccr, shadow_depth, shadow_err);
    end
    int_restore = 1'b1;
    tick();
    idle();
    tests++;
    if (shadow_err !== 1'b1 || shadow_depth !== 2'd0
        || ccr !== 4'b1010) begin
      fails++;
      $display("FAIL underflow got %b/%0d/%h exp 1/0/a",
               shadow_err, shadow_depth, ccr);
    end
  endtask

  task automatic test_overflow;
    idle();
    reset = 1'b1;
    tick();
    idle();
    wr(4'b0011);
    int_save = 1'b1;
    tick();
    idle();
    flag_valid   = 1'b1;
    flag_wr_mask = 4'hF;
    alu_flags    = 4'b1100;
    int_save     = 1'b1;
    tick();
    idle();
    tests++;
    if (shadow_depth !== 2'd2 || shadow_err !== 1'b0
        || ccr !== 4'b1100) begin
      fails++;
      $display("FAIL save2 got %0d/%b/%h exp 2/0/c",
               shadow_depth, shadow_err, ccr);
    end
    int_save = 1'b1;
    tick();
    idle();
    tests++;
    if (shadow_depth !== 2'd2 || shadow_err !== 1'b1) begin
      fails++;
      $display("FAIL overflow got %0d/%b exp 2/1",
               shadow_depth, shadow_err);
    end
    stall        = 1'b1;
    flag_valid   = 1'b1;
    flag_wr_mask = 4'hF;
    alu_flags    = 4'hF;
    int_restore  = 1'b1;
    branch_valid = 1'b1;
    branch_type  = 3'd5;
    #1;
    tests++;
    if (branch_taken !== 1'b0) begin
      fails++;
      $display("FAIL stall_taken got %b exp 0", branch_taken);
    end
    tick();
    idle();
    tests++;
    if (ccr !== 4'b1100 || shadow_depth !== 2'd2) begin
      fails++;
      $display("FAIL stall_hold got %h/%0d exp c/2",
               ccr, shadow_depth);
    end
    flush        = 1'b1;
    flag_valid   = 1'b1;
    flag_wr_mask = 4'hF;
    alu_flags    = 4'hF;
    int_restore  = 1'b1;
    branch_valid = 1'b1;
    branch_type  = 3'd5;
    #1;
    tests++;
    if (branch_taken !== 1'b0) begin
      fails++;
      $display("FAIL flush_taken got %b exp 0", branch_taken);
    end
    tick();
    idle();
    tests++;
    if (ccr !== 4'b1100 || shadow_depth !== 2'd2) begin
      fails++;
      $display("FAIL flush_hold got %h/%0d exp c/2",
               ccr, shadow_depth);
    end
    int_restore = 1'b1;
    tick();
    tick();
    idle();
    tests++;
    if (ccr !== 4'b0011 || shadow_depth !== 2'd0) begin
      fails++;
      $display("FAIL lifo got %h/%0d exp 3/0", ccr, shadow_depth);
    end
  endtask

  task automatic test_both_and_reset;
    idle();
    reset = 1'b1;
    tick();
    idle();
    wr(4'b0110);
    int_save = 1'b1;
    tick();
    idle();
    int_save    = 1'b1;
    int_restore = 1'b1;
    tick();
    idle();
    tests++;
    if (shadow_depth !== 2'd1 || shadow_err !== 1'b1
        || ccr !== 4'b0110) begin
      fails++;
      $display("FAIL both got %0d/%b/%h exp 1/1/6",
               shadow_depth, shadow_err, ccr);
    end
    reset        = 1'b1;
    flag_valid   = 1'b1;
    flag_wr_mask = 4'hF;
    alu_flags    = 4'hF;
    int_save     = 1'b1;
    tick();
    idle();
    tests++;
    if (ccr !== 4'h0 || shadow_depth !== 2'd0
        || shadow_err !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got %h/%0d/%b exp 0/0/0",
               ccr, shadow_depth, shadow_err);
    end
    int_save = 1'b1;
    tick();
    idle();
    int_restore = 1'b1;
    tick();
    idle();
    tests++;
    if (ccr !== 4'h0 || shadow_err !== 1'b0) begin
      fails++;
      $display("FAIL post_rst_stk got %h/%b exp 0/0",
               ccr, shadow_err);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_flag_write();
    test_bypass_jz();
    test_partial_mask();
    test_shadow();
    test_overflow();
    test_both_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
- Condition-code register stage directly downstream of the ALU in the execute stage.
- Latches the ALU flag vector {V,C,N,Z} under a per-instruction write mask.
- Feeds the registered carry back to the ALU for RLC/RRC, and resolves conditional branches (JZ/JN/JC/JV) with a same-cycle bypass.
- Holds a small shadow stack that saves and restores flags across interrupt entry and RTI.

Parameters:
- SHADOW_DEPTH, 2, number of nested interrupt flag snapshots (1..4).
- SP_W, 2, width of the shadow stack pointer; must hold 0..SHADOW_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  pipeline hold; freezes all state and suppresses branch_taken.
- flush  in  1  kills this cycle's flag write, branch and save/restore requests.
- alu_flags  in  4  ALU flags: [3]=V, [2]=C, [1]=N, [0]=Z.
- flag_wr_mask  in  4  per-bit enable for updating the CCR from alu_flags.
- flag_valid  in  1  qualifies flag_wr_mask this cycle.
- branch_type  in  3  0=none, 1=JZ, 2=JN, 3=JC, 4=JV, 5=JMP; 6 and 7 are treated as none.
- branch_valid  in  1  qualifies branch_type.
- int_save  in  1  push the current flags onto the shadow stack (interrupt entry).
- int_restore  in  1  pop the shadow stack into the CCR (RTI).
- ccr  out  4  registered flags.
- carry_out  out  1  equals ccr[2]; carry-in to the ALU rotates.
- branch_taken  out  1  combinational branch decision.
- shadow_err  out  1  sticky error: overflow, underflow, or save and restore in the same cycle.
- shadow_depth  out  SP_W  current number of stack entries.

Behaviour:
- Reset:
  - ccr=0, shadow_depth=0, shadow_err=0, every shadow entry=0.
  - branch_taken=0 while reset is high.
  - Reset mid-operation discards pending save/restore requests and stack contents.
- Bypass flags (combinational):
  - eff[i] = alu_flags[i] when flag_valid & flag_wr_mask[i] & ~flush; otherwise eff[i] = ccr[i].
- branch_taken:
  - Forced to 0 when stall, flush, reset or ~branch_valid.
  - Otherwise: JZ=eff[0], JN=eff[1], JC=eff[2], JV=eff[3], JMP=1, none=0.
  - Same-cycle ALU writes are visible with zero latency.
- Next CCR, when not stalled:
  1. Start from eff.
  2. If BRANCH_CLR_EN is defined and a conditional branch is taken, clear the tested bit (JMP clears nothing).
  3. int_restore (valid, no error) overrides steps 1–2: ccr <= top entry.
- Stall: ccr, the stack, shadow_depth and shadow_err all hold. Inputs are ignored that cycle.
- Shadow stack FSM states (encoded by shadow_depth):
  - EMPTY (0), PARTIAL, FULL (SHADOW_DEPTH).
  - Save (int_save & ~int_restore & ~flush & ~stall):
    - Not FULL: push eff (includes the same-cycle ALU write, before any branch clear); depth+1. The same-cycle flag write also updates the CCR.
    - FULL: no push, shadow_err <= 1.
  - Restore (int_restore & ~int_save & ~flush & ~stall):
    - Not EMPTY: ccr <= top entry; depth−1.
    - EMPTY: ccr gets the normal update, shadow_err <= 1.
  - int_save & int_restore together: stack unchanged, ccr gets the normal update, shadow_err <= 1.
- shadow_err: cleared only by reset.
- Latency:
  - Flag write to ccr/carry_out: 1 cycle.
  - Flag write to branch_taken: 0 cycles (bypass).
  - Restore to ccr: 1 cycle.

Optional Feature:
- Macro: CCR_BRANCH_CLR_EN.
- Defined: a taken JZ/JN/JC/JV clears the tested flag on the next edge. The clear applies after the same-cycle ALU merge, so the consumed flag ends at 0 even if the ALU set it that cycle.
- Undefined: branches never modify the CCR, and ccr next = eff (or the restored value).

Test Plan:
- Reset, then flag_valid=1, mask=4'b1111, alu_flags=4'b0101 -> ccr=4'b0101 and carry_out=1 one cycle later; branch_taken stays 0 with branch_valid=0.
- ccr=0; same cycle alu_flags=4'b0001, mask=4'b0001, JZ valid -> branch_taken=1 that cycle; next ccr=4'b0000 with CCR_BRANCH_CLR_EN, 4'b0001 without.
- mask=4'b0010, alu_flags=4'b1111, prior ccr=4'b0100 -> ccr=4'b0110; JC -> taken=1; JV -> taken=0.
- ccr=4'b1010, int_save -> depth=1. Write flags to 4'b0001, then int_restore -> ccr=4'b1010, depth=0. A further int_restore -> shadow_err=1, depth stays 0.
- SHADOW_DEPTH=2: three saves -> depth=2 and shadow_err=1. Assert stall with a flag write of 4'b1111 -> ccr unchanged. Flush with JMP -> branch_taken=0.
- int_save and int_restore together at depth=1 -> depth stays 1, shadow_err=1. Assert reset mid-sequence -> ccr=0, depth=0, err=0 on the next edge.
